mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single memory port between instruction fetch (IF) and the load/store path. The load/store path is driven by the decoder's memory-write and memory-read enables. The block serialises the two requesters, holds one outstanding bus transaction at a time, and returns read data or write completion to the owning requester. It also aborts a transaction that is never acknowledged, using a wait-cycle watchdog.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (DW/8 byte strobes)
- TIMEOUT, 255, maximum wait cycles for i_mem_ack before abort (1..65535)

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  reset; one clock, asynchronous, active-low
- i_if_req  in  1  fetch request; held until o_if_gnt
- i_if_addr  in  AW  fetch address
- o_if_gnt  out  1  fetch request accepted (1-cycle pulse)
- o_if_valid  out  1  fetch completed (1-cycle pulse)
- o_if_rdata  out  DW  fetched word; valid while o_if_valid
- i_ls_req  in  1  load/store request (mren|mwen); held until o_ls_gnt
- i_ls_we  in  1  1 = store, 0 = load
- i_ls_addr  in  AW  load/store address
- i_ls_wdata  in  DW  store data
- i_ls_wstrb  in  DW/8  store byte strobes
- o_ls_gnt  out  1  load/store accepted (1-cycle pulse)
- o_ls_valid  out  1  load/store completed (1-cycle pulse)
- o_ls_rdata  out  DW  load data; 0 for stores
- o_mem_req, o_mem_we  out  1  bus request / write
- o_mem_addr  out  AW  bus address
- o_mem_wdata  out  DW  bus write data
- o_mem_wstrb  out  DW/8  bus write strobes
- i_mem_ack  in  1  bus completion (1-cycle)
- i_mem_rdata  in  DW  bus read data, sampled with i_mem_ack
- o_err  out  1  timeout abort (1-cycle pulse, alongside the requester's valid)

## Operation
- FSM states: IDLE, IF_BUSY, LS_BUSY.
- IDLE:
  - If a request is selected, the block drives the matching o_*_gnt combinationally.
  - It captures addr/we/wdata/wstrb into registers, clears the wait counter and moves to *_BUSY.
  - Stores from IF are impossible; o_mem_we = 0 for fetches.
- *_BUSY:
  - o_mem_req = 1 and the bus fields come from the captured registers, stable until ack.
  - On i_mem_ack: register i_mem_rdata (0 for stores) into o_*_rdata, pulse o_*_valid next cycle, return to IDLE.
- Wait counter:
  - 16-bit; increments each BUSY cycle without ack and saturates.
  - When it reaches TIMEOUT with no ack, the block drops o_mem_req and pulses o_*_valid and o_err together next cycle, with rdata = 0. It then returns to IDLE.
- Ack in the same cycle as the timeout: the ack wins and o_err stays 0.
- i_mem_ack in IDLE is ignored.
- No grant is issued while BUSY; requests stay pending.
- o_*_rdata holds its last value between valid pulses.

## Timing
- Reset values: FSM = IDLE; every output = 0 (gnt, valid, rdata, mem_*, err); counter = 0.
- Reset mid-transaction: o_mem_req falls asynchronously and no valid is produced.
- Cycle 0: request in IDLE, gnt pulses.
- Cycle 1: o_mem_req = 1; a minimum-latency ack arrives here.
- Cycle 2: valid pulses, FSM is IDLE, and the next grant is possible in the same cycle.
- Minimum latency is 2 cycles; throughput is one transaction per 2 cycles.
- An ack at BUSY cycle k (k ≥ 1) gives valid at k+1.

## Configuration
- ARB_RR_EN defined:
  - When both request in IDLE, the grant goes to the requester not served last (1-bit last-owner register, reset = IF, so LS wins first).
  - A lone requester is always granted.
- ARB_RR_EN undefined: fixed priority, LS always beats IF.

## Test plan
- Single fetch, addr 0x100, ack on cycle 1 with rdata 0x00000013 -> gnt on cycle 0, valid on cycle 2, o_if_rdata = 0x00000013, o_err = 0.
- Store addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF, ack after 3 wait cycles:
  - o_mem_we = 1 and fields stable 4 cycles.
  - o_ls_valid 1 cycle after ack; o_ls_rdata = 0.
- Simultaneous IF and LS requests held for 4 transactions:
  - without ARB_RR_EN, grants LS, LS, LS, LS while LS is held;
  - with ARB_RR_EN, grants LS, IF, LS, IF.
- TIMEOUT = 4, no ack -> o_mem_req low after 4 BUSY cycles; o_if_valid = o_err = 1 for one cycle, rdata = 0; next request is granted normally.
- i_rst_n low mid-LS_BUSY -> o_mem_req = 0 immediately, no valid/err; after release, IDLE accepts a new fetch.
- Ack on exactly the TIMEOUT cycle -> normal completion, o_err = 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter: serialises instruction fetch and load/store onto one bus with one
// outstanding transaction and a wait-cycle watchdog. Define ARB_RR_EN for round-robin grants.
//
// state   | meaning
// IDLE    | no bus transaction; a pending request may be granted
// IF_BUSY | fetch owns the bus, waiting for ack or timeout
// LS_BUSY | load/store owns the bus, waiting for ack or timeout
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_if_req,
   input  logic [AW-1:0]   i_if_addr,
   output logic            o_if_gnt,
   output logic            o_if_valid,
   output logic [DW-1:0]   o_if_rdata,
   input  logic            i_ls_req,
   input  logic            i_ls_we,
   input  logic [AW-1:0]   i_ls_addr,
   input  logic [DW-1:0]   i_ls_wdata,
   input  logic [DW/8-1:0] i_ls_wstrb,
   output logic            o_ls_gnt,
   output logic            o_ls_valid,
   output logic [DW-1:0]   o_ls_rdata,
   output logic            o_mem_req,
   output logic            o_mem_we,
   output logic [AW-1:0]   o_mem_addr,
   output logic [DW-1:0]   o_mem_wdata,
   output logic [DW/8-1:0] o_mem_wstrb,
   input  logic            i_mem_ack,
   input  logic [DW-1:0]   i_mem_rdata,
   output logic            o_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      LS_BUSY = 2'd2
   } state_t;

   // Abort fires in the TIMEOUT-th wait cycle, so an ack in that same cycle still wins.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [15:0]     wait_cnt_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [DW/8-1:0] wstrb_q;
   logic            we_q;
   logic            if_valid_q, ls_valid_q, err_q;
   logic [DW-1:0]   if_rdata_q, ls_rdata_q;
   logic            busy, sel_if, sel_ls, grant, timeout_hit;

   assign busy        = (state_q != IDLE);
   assign timeout_hit = busy && !i_mem_ack && (wait_cnt_q == WAIT_LAST);

`ifdef ARB_RR_EN
   logic last_ls_q;

   assign sel_ls = i_ls_req && (!i_if_req || !last_ls_q);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         last_ls_q <= 1'b0;
      else if (grant)
         last_ls_q <= sel_ls;
   end
`else
   assign sel_ls = i_ls_req;
`endif

   assign sel_if = i_if_req && !sel_ls;
   assign grant  = (state_q == IDLE) && (sel_if || sel_ls);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (sel_ls)
               state_d = LS_BUSY;
            else if (sel_if)
               state_d = IF_BUSY;
         end
         IF_BUSY, LS_BUSY: begin
            if (i_mem_ack || timeout_hit)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_if_gnt    = 1'b0;
      o_ls_gnt    = 1'b0;
      if (state_q == IDLE) begin
         o_if_gnt = sel_if;
         o_ls_gnt = sel_ls;
      end
      o_mem_req   = busy;
      o_mem_we    = (state_q == LS_BUSY) && we_q;
      o_mem_addr  = busy ? addr_q  : '0;
      o_mem_wdata = busy ? wdata_q : '0;
      o_mem_wstrb = busy ? wstrb_q : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wait_cnt_q <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         we_q       <= 1'b0;
         if_valid_q <= 1'b0;
         ls_valid_q <= 1'b0;
         err_q      <= 1'b0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         if_valid_q <= (state_q == IF_BUSY) && (i_mem_ack || timeout_hit);
         ls_valid_q <= (state_q == LS_BUSY) && (i_mem_ack || timeout_hit);
         err_q      <= timeout_hit;

         if (grant) begin
            wait_cnt_q <= '0;
            if (sel_ls) begin
               addr_q  <= i_ls_addr;
               we_q    <= i_ls_we;
               wdata_q <= i_ls_wdata;
               wstrb_q <= i_ls_wstrb;
            end else begin
               addr_q  <= i_if_addr;
               we_q    <= 1'b0;
               wdata_q <= '0;
               wstrb_q <= '0;
            end
         end else if (busy && !i_mem_ack && (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
         end

         if (state_q == IF_BUSY) begin
            if (i_mem_ack)
               if_rdata_q <= i_mem_rdata;
            else if (timeout_hit)
               if_rdata_q <= '0;
         end

         if (state_q == LS_BUSY) begin
            if (i_mem_ack)
               ls_rdata_q <= we_q ? '0 : i_mem_rdata;
            else if (timeout_hit)
               ls_rdata_q <= '0;
         end
      end
   end

   assign o_if_valid = if_valid_q;
   assign o_ls_valid = ls_valid_q;
   assign o_if_rdata = if_rdata_q;
   assign o_ls_rdata = ls_rdata_q;
   assign o_err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by random traffic,
// compared against a transaction-level model of grants, latencies and completions.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_if_req = 1'b0;
   logic [AW-1:0] i_if_addr = '0;
   logic          o_if_gnt, o_if_valid;
   logic [DW-1:0] o_if_rdata;
   logic          i_ls_req = 1'b0;
   logic          i_ls_we = 1'b0;
   logic [AW-1:0] i_ls_addr = '0;
   logic [DW-1:0] i_ls_wdata = '0;
   logic [3:0]    i_ls_wstrb = '0;
   logic          o_ls_gnt, o_ls_valid;
   logic [DW-1:0] o_ls_rdata;
   logic          o_mem_req, o_mem_we;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] o_mem_wdata;
   logic [3:0]    o_mem_wstrb;
   logic          i_mem_ack = 1'b0;
   logic [DW-1:0] i_mem_rdata = '0;
   logic          o_err;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr),
      .o_if_gnt(o_if_gnt), .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata),
      .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
      .i_ls_wdata(i_ls_wdata), .i_ls_wstrb(i_ls_wstrb),
      .o_ls_gnt(o_ls_gnt), .o_ls_valid(o_ls_valid), .o_ls_rdata(o_ls_rdata),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
      .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_ls;
      bit          err;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Completion monitor: every valid pulse must match the oldest outstanding expectation.
   always @(negedge i_clk) begin
      exp_t e;
      if (o_if_valid || o_ls_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", {o_if_valid, o_ls_valid}, 2'b00);
         end else begin
            e = sb.pop_front();
            check("valid_owner", {o_if_valid, o_ls_valid}, e.is_ls ? 2'b01 : 2'b10);
            check("valid_cycle", cyc, e.cyc);
            check("err", o_err, e.err);
            check("rdata", e.is_ls ? o_ls_rdata : o_if_rdata, e.rdata);
         end
      end else if (o_err) begin
         check("err_without_valid", o_err, 1'b0);
      end
   end

   // Requesters
   bit          p_if = 0, p_ls = 0, hold_if = 0, hold_ls = 0, rand_req = 0;
   logic [31:0] r_if_addr = '0, r_ls_addr = '0, r_ls_wdata = '0;
   logic        r_ls_we = 1'b0;
   logic [3:0]  r_ls_wstrb = '0;
   // Transaction model
   bit          m_busy = 0, m_owner_ls = 0, m_last_ls = 0;
   int          m_k = 0, m_lat = 0;
   logic [31:0] m_rdata = '0, m_addr = '0, m_wdata = '0;
   logic        m_we = 1'b0;
   logic [3:0]  m_wstrb = '0;
   int          force_lat = 0;
   bit          use_force_rdata = 0;
   logic [31:0] force_rdata = '0;
   bit          dut_gl[$];

   task automatic new_if();
      p_if = 1; r_if_addr = $urandom;
   endtask

   task automatic new_ls();
      p_ls = 1; r_ls_we = 1'($urandom_range(0, 1)); r_ls_addr = $urandom;
      r_ls_wdata = $urandom; r_ls_wstrb = 4'($urandom_range(0, 15));
   endtask

   // One clock: entered just after a rising edge, leaves just after the next one.
   task automatic step();
      bit exp_ls, exp_if;
      int eff;
      if (rand_req) begin
         if (!p_if && $urandom_range(0, 2) == 0) new_if();
         if (!p_ls && $urandom_range(0, 2) == 0) new_ls();
      end
      i_if_req   = p_if;
      i_if_addr  = p_if ? r_if_addr : $urandom;
      i_ls_req   = p_ls;
      i_ls_we    = p_ls ? r_ls_we : 1'b0;
      i_ls_addr  = p_ls ? r_ls_addr : $urandom;
      i_ls_wdata = p_ls ? r_ls_wdata : $urandom;
      i_ls_wstrb = p_ls ? r_ls_wstrb : 4'h0;
      i_mem_ack  = m_busy && (m_k == m_lat);
      if (!m_busy && rand_req && $urandom_range(0, 3) == 0) i_mem_ack = 1'b1;
      i_mem_rdata = (m_busy && i_mem_ack) ? m_rdata : $urandom;

      @(negedge i_clk);
      exp_ls = 0; exp_if = 0;
      if (!m_busy) begin
`ifdef ARB_RR_EN
         exp_ls = p_ls && (!p_if || !m_last_ls);
`else
         exp_ls = p_ls;
`endif
         exp_if = p_if && !exp_ls;
      end
      check("if_gnt", o_if_gnt, exp_if);
      check("ls_gnt", o_ls_gnt, exp_ls);
      if (o_ls_gnt) dut_gl.push_back(1'b1);
      else if (o_if_gnt) dut_gl.push_back(1'b0);
      check("mem_req", o_mem_req, m_busy);
      if (m_busy) begin
         check("mem_addr", o_mem_addr, m_addr);
         check("mem_we", o_mem_we, m_we);
         if (m_owner_ls) begin
            check("mem_wdata", o_mem_wdata, m_wdata);
            check("mem_wstrb", o_mem_wstrb, m_wstrb);
         end
      end

      if (m_busy) begin
         if (m_k == m_lat || m_k == TO) m_busy = 0;
         else m_k++;
      end else if (exp_ls || exp_if) begin
         m_busy = 1; m_k = 1; m_owner_ls = exp_ls; m_last_ls = exp_ls;
         m_lat   = (force_lat != 0) ? force_lat : $urandom_range(1, 6);
         m_rdata = use_force_rdata ? force_rdata : $urandom;
         m_addr  = exp_ls ? r_ls_addr : r_if_addr;
         m_we    = exp_ls ? r_ls_we : 1'b0;
         m_wdata = r_ls_wdata;
         m_wstrb = r_ls_wstrb;
         eff = (m_lat < TO) ? m_lat : TO;
         sb.push_back('{is_ls: exp_ls, err: (m_lat > TO),
                        rdata: ((m_lat > TO) || m_we) ? 32'h0 : m_rdata,
                        cyc: cyc + eff + 1});
         if (exp_ls) p_ls = hold_ls;
         else p_if = hold_if;
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic drain(input string name);
      bit done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         if (!p_if && !p_ls && !m_busy && sb.size() == 0) done = 1;
         else step();
      end
      check(name, done, 1'b1);
   endtask

   initial begin
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_gnt", {o_if_gnt, o_ls_gnt}, 2'b00);
      check("rst_valid", {o_if_valid, o_ls_valid, o_err}, 3'b000);
      check("rst_rdata", {o_if_rdata, o_ls_rdata}, 64'h0);
      check("rst_mem", {o_mem_req, o_mem_we, o_mem_addr}, 34'h0);
      check("rst_mem_w", {o_mem_wdata, o_mem_wstrb}, 36'h0);
      i_rst_n = 1'b1;

      // Single fetch, minimum latency
      force_lat = 1; use_force_rdata = 1; force_rdata = 32'h0000_0013;
      p_if = 1; r_if_addr = 32'h100;
      drain("drain_fetch");

      // Both requesters held for four grants
      dut_gl.delete();
      force_lat = 1; use_force_rdata = 0;
      hold_if = 1; hold_ls = 1; p_if = 1; p_ls = 1;
      r_if_addr = 32'h40; r_ls_we = 1'b0; r_ls_addr = 32'h3000; r_ls_wstrb = 4'h0;
      for (int i = 0; i < 40 && dut_gl.size() < 4; i++) step();
      hold_if = 0; hold_ls = 0;
      drain("drain_both");
      check("gnt_count", (dut_gl.size() >= 4), 1'b1);
      for (int i = 0; i < 4 && i < dut_gl.size(); i++) begin
`ifdef ARB_RR_EN
         check("gnt_seq", dut_gl[i], (i % 2 == 0));
`else
         check("gnt_seq", dut_gl[i], 1'b1);
`endif
      end

      // Store, acked in the fourth wait cycle (the timeout cycle itself)
      force_lat = 4; use_force_rdata = 1; force_rdata = 32'h1234_5678;
      p_ls = 1; r_ls_we = 1'b1; r_ls_addr = 32'h2000; r_ls_wdata = 32'hDEAD_BEEF; r_ls_wstrb = 4'hF;
      drain("drain_store");

      // Fetch never acknowledged, then a normal fetch
      force_lat = 50; p_if = 1; r_if_addr = 32'h200;
      drain("drain_timeout");
      force_lat = 2; force_rdata = 32'hCAFE_0001; p_if = 1; r_if_addr = 32'h204;
      drain("drain_after_to");

      // Reset in the middle of a load
      force_lat = 50; p_ls = 1; r_ls_we = 1'b0; r_ls_addr = 32'h500;
      repeat (3) step();
      #2 i_rst_n = 1'b0;
      #1;
      check("midrst_mem_req", o_mem_req, 1'b0);
      check("midrst_valid", {o_if_valid, o_ls_valid, o_err}, 3'b000);
      m_busy = 0; m_last_ls = 0; p_if = 0; p_ls = 0; sb.delete();
      i_if_req = 1'b0; i_ls_req = 1'b0; i_mem_ack = 1'b0;
      @(posedge i_clk);
      #2 i_rst_n = 1'b1;
      force_lat = 1; force_rdata = 32'h0BAD_F00D; p_if = 1; r_if_addr = 32'h600;
      drain("drain_after_rst");

      // Random traffic
      force_lat = 0; use_force_rdata = 0; rand_req = 1;
      repeat (400) step();
      rand_req = 0;
      drain("drain_random");
      check("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
